// File: rtl/route_search_ctrl.sv
// route_search_ctrl: sequencing controller for the flood-fill route search engine.
// Accepts one request at a time, steps the engine through INIT/SEARCH (and
// optionally BACK), then holds a status/hop-count response until it is taken.
// Optional feature macro: ROUTE_CTRL_BACKTRACE_EN enables the backtrace (BACK) phase.
module route_search_ctrl #(
  parameter int POINT_NUM   = 64,
  parameter int EDGE_NUM    = 1024,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_start,
  input  logic [7:0]          req_end,
  input  logic [EDGE_NUM-1:0] req_mask,
  output logic [2:0]          eng_state,
  output logic [7:0]          eng_startPoint,
  output logic [7:0]          eng_endPoint,
  output logic [EDGE_NUM-1:0] eng_edgeMask,
  input  logic                eng_complete,
  input  logic                eng_backDone,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [7:0]          rsp_hops
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_BACK   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RS_OK           = 2'd0,
    RS_TIMEOUT      = 2'd1,
    RS_RANGE        = 2'd2,
    RS_BACK_TIMEOUT = 2'd3
  } status_e;

  localparam logic [8:0] PointLimit = 9'(POINT_NUM);
  localparam logic [7:0] CntLast    = 8'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic                ready_q, ready_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          hops_q, hops_d;
  logic [7:0]          start_q, start_d;
  logic [7:0]          end_q, end_d;
  logic [EDGE_NUM-1:0] mask_q, mask_d;
  logic                accept;

`ifndef ROUTE_CTRL_BACKTRACE_EN
  logic unused_backdone;
  assign unused_backdone = eng_backDone;
`endif

  assign accept         = req_valid && ready_q;
  assign req_ready      = ready_q;
  assign eng_state      = state_q;
  assign eng_startPoint = start_q;
  assign eng_endPoint   = end_q;
  assign eng_edgeMask   = mask_q;
  assign rsp_valid      = (state_q == ST_DONE);
  assign rsp_status     = status_q;
  assign rsp_hops       = hops_q;

  // Next-state, counter and response capture logic.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    hops_d   = hops_q;
    start_d  = start_q;
    end_d    = end_q;
    mask_d   = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start_d  = req_start;
          end_d    = req_end;
          mask_d   = req_mask;
          hops_d   = '0;
          status_d = RS_OK;
          if (({1'b0, req_start} >= PointLimit) || ({1'b0, req_end} >= PointLimit)) begin
            status_d = RS_RANGE;
            state_d  = ST_DONE;
          end else if (req_start == req_end) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        cnt_d   = '0;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (eng_complete) begin
          hops_d   = cnt_q;
          status_d = RS_OK;
`ifdef ROUTE_CTRL_BACKTRACE_EN
          cnt_d   = '0;
          state_d = ST_BACK;
`else
          state_d = ST_DONE;
`endif
        end else if (cnt_q == CntLast) begin
          hops_d   = cnt_q;
          status_d = RS_TIMEOUT;
          state_d  = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef ROUTE_CTRL_BACKTRACE_EN
      ST_BACK: begin
        if (eng_backDone) begin
          state_d = ST_DONE;
        end else if (cnt_q == CntLast) begin
          status_d = RS_BACK_TIMEOUT;
          state_d  = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is registered so it only rises one edge after reset release.
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset leaves every edge blocked.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      status_q <= RS_OK;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      hops_q   <= '0;
      start_q  <= '0;
      end_q    <= '0;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      hops_q   <= hops_d;
      start_q  <= start_d;
      end_q    <= end_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: tb/tb_route_search_ctrl.sv
// Directed self-checking bench for route_search_ctrl (TIMEOUT_CYC = 8).
module tb_route_search_ctrl;

  localparam int EN = 1024;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_start = '0;
  logic [7:0]    req_end = '0;
  logic [EN-1:0] req_mask = '0;
  logic [2:0]    eng_state;
  logic [7:0]    eng_startPoint;
  logic [7:0]    eng_endPoint;
  logic [EN-1:0] eng_edgeMask;
  logic          eng_complete = 1'b0;
  logic          eng_backDone = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [7:0]    rsp_hops;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EN-1:0] mask_a;

  route_search_ctrl #(.POINT_NUM(64), .EDGE_NUM(EN), .TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .req_mask(req_mask),
    .eng_state(eng_state), .eng_startPoint(eng_startPoint),
    .eng_endPoint(eng_endPoint), .eng_edgeMask(eng_edgeMask),
    .eng_complete(eng_complete), .eng_backDone(eng_backDone),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_hops(rsp_hops)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_state",  32'(eng_state), 0);
    check("rst_ready",  32'(req_ready), 0);
    check("rst_valid",  32'(rsp_valid), 0);
    check("rst_status", 32'(rsp_status), 0);
    check("rst_hops",   32'(rsp_hops), 0);
    check("rst_start",  32'(eng_startPoint), 0);
    check("rst_end",    32'(eng_endPoint), 0);
    check("rst_mask",   32'(&eng_edgeMask), 1);
  endtask

  // Waits (bounded) for req_ready, presents one request, returns at the
  // first falling edge after the accepting rising edge.
  task automatic send(input logic [7:0] s, input logic [7:0] e, input logic [EN-1:0] m);
    int unsigned n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_start = s;
    req_end   = e;
    req_mask  = m;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("hs_valid", 32'(rsp_valid), 0);
    check("hs_ready", 32'(req_ready), 1);
    check("hs_state", 32'(eng_state), 0);
  endtask

  initial begin
    mask_a = {16{64'hDEAD_BEEF_0123_4567}};

    // Reset values while held
    repeat (3) @(negedge CLK);
    check_reset_vals();
    RST_n = 1'b1;
    #1 check("rel_ready_early", 32'(req_ready), 0);
    @(negedge CLK);
    check("rel_ready", 32'(req_ready), 1);

    // Normal search: complete on 4th SEARCH cycle -> hops 3
    send(8'd3, 8'd9, mask_a);
    check("t2_init",  32'(eng_state), 1);
    check("t2_start", 32'(eng_startPoint), 3);
    check("t2_end",   32'(eng_endPoint), 9);
    check("t2_mask_lo", eng_edgeMask[31:0], 32'h0123_4567);
    check("t2_mask_hi", eng_edgeMask[1023:992], 32'hDEAD_BEEF);
    check("t2_ready", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t2_search", 32'(eng_state), 2);
      req_valid = 1'b1;
      req_start = 8'd40;
      req_end   = 8'd41;
    end
    @(negedge CLK);
    check("t2_search4", 32'(eng_state), 2);
    req_valid    = 1'b0;
    eng_complete = 1'b1;
    @(negedge CLK);
    eng_complete = 1'b0;
    check("t2_ign_start", 32'(eng_startPoint), 3);
    check("t2_ign_end",   32'(eng_endPoint), 9);
`ifdef ROUTE_CTRL_BACKTRACE_EN
    check("t2_back", 32'(eng_state), 3);
    check("t2_back_valid", 32'(rsp_valid), 0);
    eng_backDone = 1'b1;
    @(negedge CLK);
    eng_backDone = 1'b0;
`endif
    check("t2_done",   32'(eng_state), 4);
    check("t2_valid",  32'(rsp_valid), 1);
    check("t2_status", 32'(rsp_status), 0);
    check("t2_hops",   32'(rsp_hops), 3);
    handshake();

    // Out-of-range start -> RANGE one cycle after accept
    send(8'd70, 8'd2, ~mask_a);
    check("t3_state",  32'(eng_state), 4);
    check("t3_valid",  32'(rsp_valid), 1);
    check("t3_status", 32'(rsp_status), 2);
    check("t3_hops",   32'(rsp_hops), 0);
    check("t3_start",  32'(eng_startPoint), 70);
    handshake();

    // start == end -> OK, no INIT
    send(8'd17, 8'd17, mask_a);
    check("t4_state",  32'(eng_state), 4);
    check("t4_valid",  32'(rsp_valid), 1);
    check("t4_status", 32'(rsp_status), 0);
    check("t4_hops",   32'(rsp_hops), 0);
    handshake();

    // SEARCH timeout: INIT + 8 SEARCH cycles, DONE at 10th falling edge
    begin
      int lat = 1;
      send(8'd1, 8'd60, mask_a);
      while (!rsp_valid && lat < 50) begin
        @(negedge CLK);
        lat++;
      end
      check("t5_lat",    lat, 10);
      check("t5_status", 32'(rsp_status), 1);
      check("t5_hops",   32'(rsp_hops), 7);
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        check("t5_hold_valid",  32'(rsp_valid), 1);
        check("t5_hold_status", 32'(rsp_status), 1);
        check("t5_hold_hops",   32'(rsp_hops), 7);
      end
      handshake();
    end

    // Completion on 3rd SEARCH cycle, backtrace never finishes
    send(8'd5, 8'd6, mask_a);
    repeat (3) @(negedge CLK);
    check("t6_search", 32'(eng_state), 2);
    eng_complete = 1'b1;
    @(negedge CLK);
    eng_complete = 1'b0;
`ifdef ROUTE_CTRL_BACKTRACE_EN
    begin
      int n = 0;
      while (eng_state == 3'd3 && n < 50) begin
        @(negedge CLK);
        n++;
      end
      check("t6_back_len", n, 8);
    end
    check("t6_status", 32'(rsp_status), 3);
`else
    check("t6_status", 32'(rsp_status), 0);
`endif
    check("t6_state", 32'(eng_state), 4);
    check("t6_hops",  32'(rsp_hops), 2);
    handshake();

    // Reset mid-SEARCH, then a normal request with minimum latency
    send(8'd3, 8'd9, ~mask_a);
    repeat (5) @(negedge CLK);
    check("t7_pre_state", 32'(eng_state), 2);
    RST_n = 1'b0;
    #1 check_reset_vals();
    @(negedge CLK);
    RST_n = 1'b1;
    #1 check("t7_ready_early", 32'(req_ready), 0);
    @(negedge CLK);
    check("t7_ready", 32'(req_ready), 1);
    send(8'd3, 8'd9, mask_a);
    check("t7_init", 32'(eng_state), 1);
    @(negedge CLK);
    check("t7_search", 32'(eng_state), 2);
    eng_complete = 1'b1;
    @(negedge CLK);
    eng_complete = 1'b0;
`ifdef ROUTE_CTRL_BACKTRACE_EN
    check("t7_back", 32'(eng_state), 3);
    eng_backDone = 1'b1;
    @(negedge CLK);
    eng_backDone = 1'b0;
`endif
    check("t7_valid",  32'(rsp_valid), 1);
    check("t7_status", 32'(rsp_status), 0);
    check("t7_hops",   32'(rsp_hops), 0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
